// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
//   This is a generic control-vector pipeline. It carries decoded control
//   vectors from decode through STAGES registered stages. Stage 0 is the
//   youngest stage (execute).
//   Each stage has its own stall and flush and a valid bit. An older stall
//   freezes every younger stage. A stage that has a frozen younger
//   neighbour but is not frozen itself receives a bubble.
//
//   Optional feature macro: CTRL_PIPE_KILL_EN
//     When defined, kill masks the KILL_MASK bits of a valid instruction in
//     stage 0. The mask is applied as the instruction advances into stage 1,
//     or in place while stage 0 is held.
//     When undefined, kill and KILL_MASK are ignored.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_data    decode-stage control vector
//   in_valid   in_data carries a real instruction
//   stall      stall[i] holds stage i
//   flush      flush[i] clears stage i (overrides stall)
//   kill       exception on the instruction currently in stage 0
//   out_data   stage i vector at [i*WIDTH +: WIDTH]
//   out_valid  stage i valid
//   occupancy  number of valid stages (registered)
module ctrl_pipeline #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      STAGES    = 3,
  parameter logic [WIDTH-1:0] KILL_MASK = '1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  input  logic [STAGES-1:0]            stall,
  input  logic [STAGES-1:0]            flush,
  input  logic                         kill,
  output logic [STAGES*WIDTH-1:0]      out_data,
  output logic [STAGES-1:0]            out_valid,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  logic [STAGES*WIDTH-1:0] dataQ, dataD, prevData;
  logic [STAGES-1:0]       validQ, validD, prevValid;
  logic [STAGES-1:0]       effStall, youngerStall;
  logic [OCC_W-1:0]        occQ, occD;
  logic [WIDTH-1:0]        killed0;
  logic [WIDTH-1:0]        srcData;
  logic                    srcValid;
  logic                    killActive;

  assign killed0 = dataQ[WIDTH-1:0] & ~KILL_MASK;

`ifdef CTRL_PIPE_KILL_EN
  // A flush of stage 0 squashes the instruction, so the kill is not applied.
  // A flush of stage 1 needs no special case: flush already beats the load.
  assign killActive = kill & validQ[0] & ~flush[0];
`else
  logic unusedKill;
  assign unusedKill = kill;
  assign killActive = 1'b0;
`endif

  // Build the effective stall from the oldest stage down to the youngest.
  always_comb begin
    effStall = '0;
    effStall[STAGES-1] = stall[STAGES-1];
    for (int unsigned k = STAGES - 1; k > 0; k--) begin
      effStall[k-1] = stall[k-1] | effStall[k];
    end
  end

  // Shift these so that slot i holds what stage i-1 offers. Slot 0 is
  // always zero, so stage 0 never takes a bubble from a younger stage.
  assign youngerStall = effStall << 1;
  assign prevValid    = validQ << 1;
  assign prevData     = dataQ << WIDTH;

  always_comb begin
    dataD    = dataQ;
    validD   = validQ;
    srcData  = '0;
    srcValid = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      srcData  = prevData[i*WIDTH +: WIDTH];
      srcValid = prevValid[i];
      if (i == 0) begin
        srcData  = in_valid ? in_data : '0;
        srcValid = in_valid;
      end else if (i == 1 && killActive) begin
        srcData = killed0;
      end

      if (flush[i]) begin
        dataD[i*WIDTH +: WIDTH] = '0;
        validD[i]               = 1'b0;
      end else if (effStall[i]) begin
        if (i == 0 && killActive) begin
          dataD[WIDTH-1:0] = killed0;
        end
      end else if (youngerStall[i]) begin
        dataD[i*WIDTH +: WIDTH] = '0;
        validD[i]               = 1'b0;
      end else if (i == 0 && STAGES == 1 && killActive) begin
        // A single-stage pipe has no stage 1 to carry the masked copy.
        dataD[WIDTH-1:0] = killed0;
      end else begin
        dataD[i*WIDTH +: WIDTH] = srcData;
        validD[i]               = srcValid;
      end
    end
  end

  always_comb begin
    occD = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      occD = occD + OCC_W'(validD[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataQ  <= '0;
      validQ <= '0;
      occQ   <= '0;
    end else begin
      dataQ  <= dataD;
      validQ <= validD;
      occQ   <= occD;
    end
  end

  assign out_data  = dataQ;
  assign out_valid = validQ;
  assign occupancy = occQ;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline (WIDTH=16, STAGES=3, KILL_MASK=16'h0010).
// The stimulus pushes the expected post-edge state. A monitor pops and
// compares that state just after the edge, or on demand for asynchronous
// checks.
module tb_ctrl_pipeline;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] inData = '0;
  logic        inValid = 1'b0;
  logic [2:0]  stall = '0;
  logic [2:0]  flush = '0;
  logic        kill = 1'b0;
  logic [47:0] outData;
  logic [2:0]  outValid;
  logic [1:0]  occupancy;

  always #5 clk = ~clk;

  ctrl_pipeline #(
    .WIDTH(16),
    .STAGES(3),
    .KILL_MASK(16'h0010)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(inData),
    .in_valid(inValid),
    .stall(stall),
    .flush(flush),
    .kill(kill),
    .out_data(outData),
    .out_valid(outValid),
    .occupancy(occupancy)
  );

`ifdef CTRL_PIPE_KILL_EN
  localparam logic [15:0] KX = 16'h0003;
`else
  localparam logic [15:0] KX = 16'h0013;
`endif

  typedef struct {
    string       name;
    logic [47:0] data;
    logic [2:0]  valid;
    logic [1:0]  occ;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   compared = 0;
  int   mismatched = 0;
  event checkNow;

  task automatic chk(input string name, input string what,
                     input logic [47:0] act, input logic [47:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s.%s: got %h expected %h", name, what, act, exp);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge clk or checkNow);
      #1;
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        chk(cur.name, "data", outData, cur.data);
        chk(cur.name, "valid", {45'd0, outValid}, {45'd0, cur.valid});
        chk(cur.name, "occ", {46'd0, occupancy}, {46'd0, cur.occ});
      end
    end
  end

  task automatic push(input string name, input logic [15:0] s0,
                      input logic [15:0] s1, input logic [15:0] s2,
                      input logic [2:0] v, input logic [1:0] o);
    exp_t e;
    e.name  = name;
    e.data  = {s2, s1, s0};
    e.valid = v;
    e.occ   = o;
    sb.push_back(e);
  endtask

  task automatic step(input string name, input logic [15:0] d, input logic dv,
                      input logic [2:0] st, input logic [2:0] fl, input logic kl,
                      input logic [15:0] s0, input logic [15:0] s1,
                      input logic [15:0] s2, input logic [2:0] v,
                      input logic [1:0] o);
    @(negedge clk);
    inData  = d;
    inValid = dv;
    stall   = st;
    flush   = fl;
    kill    = kl;
    push(name, s0, s1, s2, v, o);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end

  initial begin
    #12;
    push("reset", '0, '0, '0, 3'b000, 2'd0);
    ->checkNow;
    @(negedge clk);
    rst = 1'b1;

    //    name       in       v     stall   flush   kill  s0       s1       s2       valid   occ
    step("fill1",   16'hA001, 1'b1, 3'b000, 3'b000, 1'b0, 16'hA001, 16'h0000, 16'h0000, 3'b001, 2'd1);
    step("fill2",   16'hA002, 1'b1, 3'b000, 3'b000, 1'b0, 16'hA002, 16'hA001, 16'h0000, 3'b011, 2'd2);
    step("fill3",   16'hA003, 1'b1, 3'b000, 3'b000, 1'b0, 16'hA003, 16'hA002, 16'hA001, 3'b111, 2'd3);
    step("stallO1", 16'hA004, 1'b1, 3'b100, 3'b000, 1'b0, 16'hA003, 16'hA002, 16'hA001, 3'b111, 2'd3);
    step("stallO2", 16'hA004, 1'b1, 3'b100, 3'b000, 1'b0, 16'hA003, 16'hA002, 16'hA001, 3'b111, 2'd3);
    step("loadB0",  16'h00B0, 1'b1, 3'b000, 3'b000, 1'b0, 16'h00B0, 16'hA003, 16'hA002, 3'b111, 2'd3);
    step("bubble",  16'hC001, 1'b1, 3'b001, 3'b000, 1'b0, 16'h00B0, 16'h0000, 16'hA003, 3'b101, 2'd2);
    step("afterBub",16'hC001, 1'b1, 3'b000, 3'b000, 1'b0, 16'hC001, 16'h00B0, 16'h0000, 3'b011, 2'd2);
    step("fillC",   16'hC002, 1'b1, 3'b000, 3'b000, 1'b0, 16'hC002, 16'hC001, 16'h00B0, 3'b111, 2'd3);
    step("flushStl",16'hC003, 1'b1, 3'b111, 3'b010, 1'b0, 16'hC002, 16'h0000, 16'h00B0, 3'b101, 2'd2);
    step("invalIn", 16'hFFFF, 1'b0, 3'b000, 3'b000, 1'b0, 16'h0000, 16'hC002, 16'h0000, 3'b010, 2'd1);
    step("load13",  16'h0013, 1'b1, 3'b000, 3'b000, 1'b0, 16'h0013, 16'h0000, 16'hC002, 3'b101, 2'd2);
    step("killAdv", 16'h0013, 1'b1, 3'b000, 3'b000, 1'b1, 16'h0013, KX,       16'h0000, 3'b011, 2'd2);
    step("killHold",16'h0099, 1'b1, 3'b001, 3'b000, 1'b1, KX,       16'h0000, KX,       3'b101, 2'd2);
    step("drain",   16'h0000, 1'b0, 3'b000, 3'b000, 1'b0, 16'h0000, KX,       16'h0000, 3'b010, 2'd1);
    step("flushO",  16'hA00A, 1'b1, 3'b100, 3'b100, 1'b0, 16'h0000, KX,       16'h0000, 3'b010, 2'd1);
    step("fill1111",16'h1111, 1'b1, 3'b000, 3'b000, 1'b0, 16'h1111, 16'h0000, KX,       3'b101, 2'd2);
    step("fill2222",16'h2222, 1'b1, 3'b000, 3'b000, 1'b0, 16'h2222, 16'h1111, 16'h0000, 3'b011, 2'd2);
    step("fill3333",16'h3333, 1'b1, 3'b000, 3'b000, 1'b0, 16'h3333, 16'h2222, 16'h1111, 3'b111, 2'd3);

    #2;
    rst = 1'b0;
    push("asyncRst", '0, '0, '0, 3'b000, 2'd0);
    ->checkNow;

    step("rstHeld", 16'h5555, 1'b1, 3'b000, 3'b000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 2'd0);
    @(negedge clk);
    inValid = 1'b0;
    rst     = 1'b1;
    step("postRst", 16'h4444, 1'b1, 3'b000, 3'b000, 1'b0, 16'h4444, 16'h0000, 16'h0000, 3'b001, 2'd1);

    for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Parametrised control-signal pipeline carrying decoded control vectors from the decode stage through STAGES downstream pipeline registers, e.g. execute, memory and writeback. It replaces hand-packed per-stage control registers with one generic block. Each stage has its own stall and flush, plus a valid bit, with stall propagation toward younger stages and automatic bubble insertion. Optional exception-kill masking clears selected write-enable bits of an instruction that faults in stage 0.

## Interface
Parameters:
- WIDTH, 16, control-vector width per stage
- STAGES, 3, number of pipeline stages (≥1); stage 0 is youngest (execute)
- KILL_MASK, {WIDTH{1'b1}}, bits cleared on kill, e.g. regwrite/hilowrite/cp0write positions

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_data  in  WIDTH  decode-stage control vector
- in_valid  in  1  in_data carries a real instruction
- stall  in  STAGES  stall[i] holds stage i
- flush  in  STAGES  flush[i] clears stage i
- kill  in  1  exception (e.g. overflow) on the instruction currently in stage 0
- out_data  out  STAGES*WIDTH  stage i vector at [i*WIDTH +: WIDTH]
- out_valid  out  STAGES  stage i valid
- occupancy  out  $clog2(STAGES+1)  number of valid stages

## Operation
- Effective stall: es[STAGES-1]=stall[STAGES-1]; es[i]=stall[i] | es[i+1]. An older stall always freezes all younger stages, so no instruction is overwritten.
- Per stage i, at each edge, the first matching rule applies:
  1. flush[i]: data←0, valid←0. This overrides stall.
  2. es[i]: hold.
  3. i>0 and es[i-1]: bubble (data←0, valid←0).
  4. Load from the source. For i=0, the source is in_data/in_valid, with data forced to 0 when in_valid=0. For i>0, the source is stage i-1.
- Kill applies only when stage 0 is valid:
  - If stage 0 advances into stage 1 on that edge, stage 1 loads stage0 & ~KILL_MASK. valid stays 1 so the instruction still reaches writeback for exception reporting.
  - If stage 0 is held (es[0]=1, no flush[0]), stage 0 is rewritten in place as stage0 & ~KILL_MASK. The masking is sticky.
  - If STAGES=1, the in-place rule always applies.
  - flush[1] or flush[0] takes priority over kill.
- occupancy is a registered popcount of the next-state valid vector. It is always equal to the popcount of out_valid.
- Reset values: out_data=0, out_valid=0, occupancy=0.

## Timing
- Latency: in_data is visible at stage 0 one cycle after the edge that samples it. Stage k is visible k+1 cycles after sampling, absent stalls.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset assertion clears all stages immediately, asynchronously, even mid-stall. Deassertion is synchronised by the caller.
- Simultaneous stall[i] and flush[i] results in a flush. Simultaneous kill and stall[0] results in in-place masking.
- Stall of the oldest stage with all stalls asserted: the pipeline is fully frozen and in_data is dropped. The hazard unit must hold decode.

## Configuration
- CTRL_PIPE_KILL_EN defined: kill is functional as above.
- CTRL_PIPE_KILL_EN undefined: the kill port is present but ignored, KILL_MASK has no effect, and vectors pass unmodified.

## Test plan
- Reset then stream: WIDTH=16, STAGES=3, in_data=16'hA001,A002,A003 valid on consecutive cycles. Stage 2 shows 16'hA001 three cycles after the first sample, and occupancy reaches 3.
- Stall propagation: pipeline holds A1/A2/A3 in stages 0/1/2, stall=3'b100 for 2 cycles. All stages hold, and new in_data is not loaded.
- Bubble: stall=3'b001 for 1 cycle with stage 0=16'hB0. Stage 1 becomes 0 with valid 0, stage 2 takes the old stage 1, and occupancy drops by 1.
- Flush over stall: stall=3'b111 and flush=3'b010 together. Only stage 1 is cleared to 0/valid 0, and stages 0 and 2 hold.
- Kill (macro on, KILL_MASK=16'h0010): stage 0=16'h0013 valid, kill=1, no stall. Stage 1 becomes 16'h0003 with valid 1. Repeating with stall[0]=1 makes stage 0 become 16'h0003 in place.
- Async reset mid-stream: drop rst between edges with 3 valid stages. out_valid=0, out_data=0 and occupancy=0 before the next edge.
